// File: rtl/mult_div_unit_pkg.sv
// Shared CPU defines for the HI/LO multiply-divide unit: operation codes,
// FSM state encoding and divide latency.
package mult_div_unit_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MADD  = 4'd5,
      MD_MADDU = 4'd6,
      MD_MSUB  = 4'd7,
      MD_MSUBU = 4'd8
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_t;

   localparam int DIV_CYCLES = 32;

   function automatic logic is_mul_op(input md_op_t op);
      return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
   endfunction

   function automatic logic is_div_op(input md_op_t op);
      return op inside {MD_DIV, MD_DIVU};
   endfunction

   function automatic logic is_signed_op(input md_op_t op);
      return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
   endfunction

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per step.
// Exposes the next-step quotient/remainder so the caller can capture the final step.
module div_core
   import mult_div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quo_next,
   output logic [31:0] rem_next,
   output logic        last
);

   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic [4:0]  cnt_q;
   logic [32:0] shifted;
   logic        fits;

   // The trial subtraction is done in 32 bits: when it succeeds the true
   // difference is below the divisor, so the dropped carry is always zero.
   always_comb begin
      shifted  = {rem_q, quo_q[31]};
      fits     = (shifted >= {1'b0, dvs_q});
      rem_next = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];
      quo_next = {quo_q[30:0], fits};
   end

   assign last = (cnt_q == 5'(DIV_CYCLES - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
         cnt_q <= '0;
      end else if (step) begin
         rem_q <= rem_next;
         quo_q <= quo_next;
         cnt_q <= cnt_q + 5'd1;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: single-cycle multiply(-accumulate) and a
// 32-step iterative divide, stalling the pipeline until the result is written.
module mult_div_unit
   import mult_div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  md_op_t      EXE_MDOp,
   input  logic        EXE_MDStart,
   input  logic        EXE_Flush,
   input  logic [31:0] EXE_SrcA,
   input  logic [31:0] EXE_SrcB,
   input  logic [31:0] HI_in,
   input  logic [31:0] LO_in,
   output logic        MULT_DIV_finish,
   output logic [31:0] EXE_MULTDIVtoHI,
   output logic [31:0] EXE_MULTDIVtoLO,
   output logic        MULT_DIV_busy
);

   md_state_t   state_q, state_d;
   md_op_t      op_q;
   logic [31:0] a_q, b_q, hi_q, lo_q;
   logic        q_neg_q, r_neg_q, dvs_zero_q;

   logic        accept, op_signed, div_last;
   logic [31:0] a_mag, b_mag, quo_next, rem_next;
   logic [63:0] a_ext, b_ext, mul_res;
   logic [31:0] div_hi, div_lo;

   assign accept    = (state_q == ST_IDLE) && EXE_MDStart && !EXE_Flush &&
                      (is_mul_op(EXE_MDOp) || is_div_op(EXE_MDOp));
   assign op_signed = is_signed_op(EXE_MDOp);
   assign a_mag     = (op_signed && EXE_SrcA[31]) ? -EXE_SrcA : EXE_SrcA;
   assign b_mag     = (op_signed && EXE_SrcB[31]) ? -EXE_SrcB : EXE_SrcB;

   div_core u_div_core (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && is_div_op(EXE_MDOp)),
      .step     (state_q == ST_DIV),
      .dividend (a_mag),
      .divisor  (b_mag),
      .quo_next (quo_next),
      .rem_next (rem_next),
      .last     (div_last)
   );

   // A 64x64 product truncated to 64 bits is correct for signed and unsigned alike.
   always_comb begin
      a_ext   = is_signed_op(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      b_ext   = is_signed_op(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      mul_res = a_ext * b_ext;
      if (op_q inside {MD_MADD, MD_MADDU})
         mul_res = {hi_q, lo_q} + mul_res;
      else if (op_q inside {MD_MSUB, MD_MSUBU})
         mul_res = {hi_q, lo_q} - mul_res;
   end

   always_comb begin
      if (dvs_zero_q) begin
         div_hi = a_q;
         div_lo = 32'hFFFF_FFFF;
      end else begin
         div_hi = r_neg_q ? -rem_next : rem_next;
         div_lo = q_neg_q ? -quo_next : quo_next;
      end
   end

   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = is_mul_op(EXE_MDOp) ? ST_MUL : ST_DIV;
         ST_MUL:  state_d = EXE_Flush ? ST_IDLE : ST_DONE;
         ST_DIV:  if (EXE_Flush) state_d = ST_IDLE;
                  else if (div_last) state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         op_q       <= MD_NONE;
         a_q        <= '0;
         b_q        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         dvs_zero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q       <= EXE_MDOp;
            a_q        <= EXE_SrcA;
            b_q        <= EXE_SrcB;
            hi_q       <= HI_in;
            lo_q       <= LO_in;
            q_neg_q    <= op_signed && (EXE_SrcA[31] ^ EXE_SrcB[31]);
            r_neg_q    <= op_signed && EXE_SrcA[31];
            dvs_zero_q <= (EXE_SrcB == 32'd0);
         end
      end
   end

   // Results are loaded only on entry to DONE and held otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         EXE_MULTDIVtoHI <= '0;
         EXE_MULTDIVtoLO <= '0;
      end else if (state_q == ST_MUL && !EXE_Flush) begin
         EXE_MULTDIVtoHI <= mul_res[63:32];
         EXE_MULTDIVtoLO <= mul_res[31:0];
      end else if (state_q == ST_DIV && div_last && !EXE_Flush) begin
         EXE_MULTDIVtoHI <= div_hi;
         EXE_MULTDIVtoLO <= div_lo;
      end
   end

   assign MULT_DIV_finish = (state_q == ST_DONE);
   assign MULT_DIV_busy   = rst && ((state_q == ST_MUL) || (state_q == ST_DIV) || accept);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: multiply family, divide
// family with corner cases, flush, start/flush collision and async reset.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        clk;
   logic        rst;
   md_op_t      EXE_MDOp;
   logic        EXE_MDStart;
   logic        EXE_Flush;
   logic [31:0] EXE_SrcA, EXE_SrcB, HI_in, LO_in;
   logic        MULT_DIV_finish;
   logic [31:0] EXE_MULTDIVtoHI, EXE_MULTDIVtoLO;
   logic        MULT_DIV_busy;

   int n_checks = 0;
   int n_errors = 0;

   mult_div_unit dut (
      .clk             (clk),
      .rst             (rst),
      .EXE_MDOp        (EXE_MDOp),
      .EXE_MDStart     (EXE_MDStart),
      .EXE_Flush       (EXE_Flush),
      .EXE_SrcA        (EXE_SrcA),
      .EXE_SrcB        (EXE_SrcB),
      .HI_in           (HI_in),
      .LO_in           (LO_in),
      .MULT_DIV_finish (MULT_DIV_finish),
      .EXE_MULTDIVtoHI (EXE_MULTDIVtoHI),
      .EXE_MULTDIVtoLO (EXE_MULTDIVtoLO),
      .MULT_DIV_busy   (MULT_DIV_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock, drop the start request, and settle before sampling.
   task automatic tick_clear();
      @(posedge clk);
      #1;
      EXE_MDStart = 1'b0;
      EXE_MDOp    = MD_NONE;
      #1;
   endtask

   task automatic issue(input string tag, input md_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
      EXE_MDOp    = op;
      EXE_SrcA    = a;
      EXE_SrcB    = b;
      HI_in       = hi;
      LO_in       = lo;
      EXE_MDStart = 1'b1;
      #1;
      check({tag, "_busy_T"}, {31'd0, MULT_DIV_busy}, 32'd1);
   endtask

   task automatic mul_test(input string tag, input md_op_t op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      issue(tag, op, a, b, hi, lo);
      tick_clear();
      check({tag, "_busy_T1"},   {31'd0, MULT_DIV_busy},   32'd1);
      check({tag, "_finish_T1"}, {31'd0, MULT_DIV_finish}, 32'd0);
      tick_clear();
      check({tag, "_finish_T2"}, {31'd0, MULT_DIV_finish}, 32'd1);
      check({tag, "_busy_T2"},   {31'd0, MULT_DIV_busy},   32'd0);
      check({tag, "_hi"}, EXE_MULTDIVtoHI, exp_hi);
      check({tag, "_lo"}, EXE_MULTDIVtoLO, exp_lo);
      tick_clear();
      check({tag, "_finish_T3"}, {31'd0, MULT_DIV_finish}, 32'd0);
      check({tag, "_hi_held"}, EXE_MULTDIVtoHI, exp_hi);
   endtask

   // A spurious MULTU request is raised mid-divide; it must have no effect.
   task automatic div_test(input string tag, input md_op_t op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
      issue(tag, op, a, b, 32'h0, 32'h0);
      for (int i = 1; i <= 32; i++) begin
         tick_clear();
         check({tag, "_busy_iter"},   {31'd0, MULT_DIV_busy},   32'd1);
         check({tag, "_finish_iter"}, {31'd0, MULT_DIV_finish}, 32'd0);
         if (i == 5) begin
            EXE_MDOp    = MD_MULTU;
            EXE_SrcA    = 32'd3;
            EXE_SrcB    = 32'd3;
            EXE_MDStart = 1'b1;
            #1;
            check({tag, "_ignored_start_busy"}, {31'd0, MULT_DIV_busy}, 32'd1);
         end
      end
      tick_clear();
      check({tag, "_finish_T33"}, {31'd0, MULT_DIV_finish}, 32'd1);
      check({tag, "_busy_T33"},   {31'd0, MULT_DIV_busy},   32'd0);
      check({tag, "_hi"}, EXE_MULTDIVtoHI, exp_hi);
      check({tag, "_lo"}, EXE_MULTDIVtoLO, exp_lo);
      tick_clear();
      check({tag, "_finish_T34"}, {31'd0, MULT_DIV_finish}, 32'd0);
   endtask

   initial begin
      rst         = 1'b0;
      EXE_MDOp    = MD_NONE;
      EXE_MDStart = 1'b0;
      EXE_Flush   = 1'b0;
      EXE_SrcA    = '0;
      EXE_SrcB    = '0;
      HI_in       = '0;
      LO_in       = '0;
      #1;
      check("rst_finish", {31'd0, MULT_DIV_finish}, 32'd0);
      check("rst_busy",   {31'd0, MULT_DIV_busy},   32'd0);
      check("rst_hi", EXE_MULTDIVtoHI, 32'h0);
      check("rst_lo", EXE_MULTDIVtoLO, 32'h0);
      #12 rst = 1'b1;
      tick_clear();

      mul_test("mult",  MD_MULT,  32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      mul_test("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'h0000_0001, 32'hFFFF_FFFE);
      mul_test("madd",  MD_MADD,  32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0);
      mul_test("msub",  MD_MSUB,  32'h1, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      mul_test("maddu", MD_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'hFFFF_FFFE, 32'h0000_0002);
      mul_test("msubu", MD_MSUBU, 32'd3, 32'd5, 32'h0, 32'd20, 32'h0, 32'd5);

      div_test("div_neg",  MD_DIV,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      div_test("divu_z",   MD_DIVU, 32'd100, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF);
      div_test("div_ovf",  MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      div_test("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF);

      // Start and flush together: request dropped, no result ever appears.
      EXE_MDOp    = MD_MULT;
      EXE_SrcA    = 32'd7;
      EXE_SrcB    = 32'd7;
      EXE_MDStart = 1'b1;
      EXE_Flush   = 1'b1;
      #1;
      check("coll_busy_T", {31'd0, MULT_DIV_busy}, 32'd0);
      tick_clear();
      EXE_Flush = 1'b0;
      #1;
      check("coll_busy_T1",   {31'd0, MULT_DIV_busy},   32'd0);
      check("coll_finish_T1", {31'd0, MULT_DIV_finish}, 32'd0);
      tick_clear();
      check("coll_finish_T2", {31'd0, MULT_DIV_finish}, 32'd0);
      check("coll_lo_held", EXE_MULTDIVtoLO, 32'h0FFF_FFFF);

      // Flush during divide iteration 10, then a multiply the very next cycle.
      issue("flush_div", MD_DIV, 32'd1000, 32'd3, 32'h0, 32'h0);
      for (int i = 1; i <= 11; i++) tick_clear();
      check("flush_busy_iter10", {31'd0, MULT_DIV_busy}, 32'd1);
      EXE_Flush = 1'b1;
      @(posedge clk);
      #1;
      EXE_Flush = 1'b0;
      #1;
      check("flush_busy_after",   {31'd0, MULT_DIV_busy},   32'd0);
      check("flush_finish_after", {31'd0, MULT_DIV_finish}, 32'd0);
      check("flush_lo_held", EXE_MULTDIVtoLO, 32'h0FFF_FFFF);
      mul_test("post_flush", MD_MULTU, 32'h0001_2345, 32'h0001_0001, 32'h0, 32'h0,
               32'h0000_0001, 32'h2346_2345);

      // Asynchronous reset mid-divide, asserted and released between clock edges.
      issue("rst_div", MD_DIVU, 32'd50, 32'd7, 32'h0, 32'h0);
      for (int i = 1; i <= 5; i++) tick_clear();
      #1 rst = 1'b0;
      #1;
      check("midrst_finish", {31'd0, MULT_DIV_finish}, 32'd0);
      check("midrst_busy",   {31'd0, MULT_DIV_busy},   32'd0);
      check("midrst_hi", EXE_MULTDIVtoHI, 32'h0);
      check("midrst_lo", EXE_MULTDIVtoLO, 32'h0);
      #2 rst = 1'b1;
      div_test("after_rst", MD_DIVU, 32'd9, 32'd2, 32'd1, 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port EXE_MDOp  in  4  operation code of type md_op_t (NONE, MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU).
REQ-004 SHALL have port EXE_MDStart  in  1  request to start the operation from the EXE stage.
REQ-005 SHALL have port EXE_Flush  in  1  cancel any operation (exception or branch flush).
REQ-006 SHALL have ports EXE_SrcA, EXE_SrcB  in  32 each  rs and rt operands.
REQ-007 SHALL have ports HI_in, LO_in  in  32 each  current HI/LO values, used by the MADD and MSUB families.
REQ-008 SHALL have port MULT_DIV_finish  out  1  one-cycle write strobe to HI/LO.
REQ-009 SHALL have ports EXE_MULTDIVtoHI, EXE_MULTDIVtoLO  out  32 each  result to be written to HI/LO.
REQ-010 SHALL have port MULT_DIV_busy  out  1  pipeline stall request.

Function
REQ-011 SHALL implement an FSM with states IDLE, MUL, DIV and DONE.
REQ-012 SHALL accept a request in IDLE when EXE_MDStart=1, EXE_MDOp!=NONE and EXE_Flush=0, registering operands, op, HI_in and LO_in at that edge.
REQ-013 SHALL transition IDLE->MUL for the MULT, MULTU, MADD, MADDU, MSUB and MSUBU ops, and IDLE->DIV for DIV and DIVU.
REQ-014 SHALL compute the product in MUL in one cycle and then go MUL->DONE.
REQ-015 SHALL perform a radix-2 restoring divide in DIV over exactly 32 iterations, tracked by a 5-bit counter, then go DIV->DONE.
REQ-016 SHALL, with the request accepted at the end of cycle T, assert MULT_DIV_finish in cycle T+2 for multiply ops and in cycle T+33 for divide ops.
REQ-017 SHALL assert MULT_DIV_finish only in DONE, for exactly one cycle, with both result outputs valid in that cycle, then go DONE->IDLE.
REQ-018 SHALL drive MULT_DIV_busy=1 in MUL and DIV, and in IDLE whenever a request is being accepted; busy SHALL be 0 in DONE so the instruction advances in the same cycle as the HI/LO write.
REQ-019 SHALL ignore EXE_MDStart in any state other than IDLE.
REQ-020 SHALL, when EXE_Flush=1 in any state, return to IDLE at the next edge with no finish pulse; when start and flush coincide, the request SHALL be ignored.
REQ-021 SHALL form MULT/MULTU results as {HI,LO} = 64-bit signed/unsigned product.
REQ-022 SHALL form MADD/MADDU/MSUB/MSUBU results as {HI_in,LO_in} plus or minus the product, modulo 2^64.
REQ-023 SHALL give DIV/DIVU results as LO=quotient and HI=remainder.
REQ-024 SHALL perform signed divide on magnitudes, negate the quotient when operand signs differ, and give the remainder the sign of the dividend.
REQ-025 SHALL return, for 0x80000000 / 0xFFFFFFFF signed, LO=0x80000000 and HI=0.
REQ-026 SHALL, for divisor 0 (signed or unsigned), return LO=0xFFFFFFFF and HI=dividend, with unchanged latency.
REQ-027 SHALL hold both result outputs at their last values outside DONE.

Reset
REQ-028 SHALL, while rst=0, force state=IDLE, counter=0, MULT_DIV_finish=0, MULT_DIV_busy=0, and both result outputs to 0x00000000, immediately and independent of clk.
REQ-029 SHALL abort an operation in progress on reset with no finish pulse, and SHALL accept a new request in the first cycle after rst deasserts.

Structure
REQ-030 SHALL take md_op_t, the FSM state enum and the constant DIV_CYCLES=32 from the shared CPU defines package.
REQ-031 SHALL place the iterative divide datapath (partial remainder, quotient shift, counter) in one sub-module, div_core; the multiply stays inline.

Verification
REQ-032 SHALL cover: MULT 0xFFFFFFFF*0x2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE at T+2; MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 SHALL cover: DIV 0xFFFFFFF9 (-7) / 0x2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, finish at T+33, busy=1 from T through T+32.
REQ-034 SHALL cover: DIVU 100/0 -> HI=0x00000064, LO=0xFFFFFFFF at T+33.
REQ-035 SHALL cover: MADD 1*1 with HI_in=0, LO_in=0xFFFFFFFF -> HI=1, LO=0; MSUB 1*1 with HI_in=LO_in=0 -> HI=LO=0xFFFFFFFF.
REQ-036 SHALL cover: flush at DIV iteration 10 -> no finish pulse, busy=0 next cycle; a MULT started the following cycle finishes correctly 2 cycles later.
REQ-037 SHALL cover: rst driven low mid-DIV, away from any clk edge -> finish, busy and both result outputs read 0 immediately; a DIVU 9/2 started after release -> LO=4, HI=1.
